// File: rtl/rv32_pipe_pkg.sv
// rtl/rv32_pipe_pkg.sv - RV32I pipeline opcodes, func3 codes, ALU modes and stage structs
package rv32_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_BR
    } alu_mode_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      ALUOp;
        logic [2:0]      func3;
        logic            func7;
        logic [4:0]      rd;
        logic            valid;
    } EX_STATE;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic [2:0]      func3;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            valid;
        logic            misaligned;
    } MEM_STATE;

endpackage

// File: rtl/rv32_branch_cmp.sv
// rtl/rv32_branch_cmp.sv - RV32I branch condition evaluation
import rv32_pipe_pkg::*;

module rv32_branch_cmp (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_func3,
    output logic            o_taken
);

    // Evaluate the branch condition; reserved encodings 010/011 never branch
    always_comb begin
        o_taken = 1'b0;
        case (i_func3)
            F3_BEQ:  o_taken = (i_a == i_b);
            F3_BNE:  o_taken = (i_a != i_b);
            F3_BLT:  o_taken = ($signed(i_a) <  $signed(i_b));
            F3_BGE:  o_taken = ($signed(i_a) >= $signed(i_b));
            F3_BLTU: o_taken = (i_a <  i_b);
            F3_BGEU: o_taken = (i_a >= i_b);
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_ex_alu.sv
// rtl/rv32_ex_alu.sv - RV32I execute-stage ALU, jump resolution and EX/MEM register (option: ALU_JMP_MISALIGN_EN)
import rv32_pipe_pkg::*;

module rv32_ex_alu (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_A,
    input  logic [XLEN-1:0] i_B,
    input  logic [XLEN-1:0] i_Imm_SignExt,
    input  logic [XLEN-1:0] i_NPC,
    input  logic [6:0]      i_ALUop,
    input  logic [2:0]      i_func3,
    input  logic            i_func7,
    input  EX_STATE         i_ex_state,
    output logic [XLEN-1:0] o_ALUOutput,
    output MEM_STATE        o_mem_state,
    output logic [XLEN-1:0] o_jmp_pc,
    output logic            o_jmp
);

    alu_mode_e       w_mode;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_shamt;
    logic            w_taken;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_branch;
    logic            w_jmp_req;
    logic            w_misaligned;
    logic            w_unused;
    MEM_STATE        r_mem_state;

    // Opcode and func fields are taken from the dedicated ports; the struct copies are redundant
    assign w_unused = ^{i_ex_state.ALUOp, i_ex_state.func7};

    rv32_branch_cmp u_branch_cmp (
        .i_a     (i_A),
        .i_b     (i_B),
        .i_func3 (i_func3),
        .o_taken (w_taken)
    );

    // Decode opcode/func fields into an ALU mode and its two operands
    always_comb begin
        w_mode = ALU_NONE;
        w_op_a = '0;
        w_op_b = '0;
        case (i_ALUop)
            OP_LUI: begin
                w_mode = ALU_ADD;
                w_op_b = i_Imm_SignExt;
            end
            OP_AUIPC: begin
                w_mode = ALU_ADD;
                w_op_a = i_NPC;
                w_op_b = i_Imm_SignExt;
            end
            OP_JAL, OP_JALR: begin
                w_mode = ALU_ADD;
                w_op_a = i_NPC;
                w_op_b = 32'd4;
            end
            OP_LOAD, OP_STORE: begin
                w_mode = ALU_ADD;
                w_op_a = i_A;
                w_op_b = i_Imm_SignExt;
            end
            OP_BRANCH: begin
                w_mode = ALU_BR;
            end
            OP_IMM, OP_OP: begin
                w_op_a = i_A;
                w_op_b = (i_ALUop == OP_IMM) ? i_Imm_SignExt : i_B;
                case (i_func3)
                    F3_ADD:  w_mode = (i_ALUop == OP_OP && i_func7) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  w_mode = ALU_SLL;
                    F3_SLT:  w_mode = ALU_SLT;
                    F3_SLTU: w_mode = ALU_SLTU;
                    F3_XOR:  w_mode = ALU_XOR;
                    F3_SR:   w_mode = i_func7 ? ALU_SRA : ALU_SRL;
                    F3_OR:   w_mode = ALU_OR;
                    default: w_mode = ALU_AND;
                endcase
            end
            default: w_mode = ALU_NONE;
        endcase
    end

    assign w_shamt = w_op_b[4:0];

    // Compute the ALU result for the decoded mode
    always_comb begin
        o_ALUOutput = '0;
        case (w_mode)
            ALU_ADD:  o_ALUOutput = w_op_a + w_op_b;
            ALU_SUB:  o_ALUOutput = w_op_a - w_op_b;
            ALU_SLL:  o_ALUOutput = w_op_a << w_shamt;
            ALU_SLT:  o_ALUOutput = {31'b0, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLTU: o_ALUOutput = {31'b0, w_op_a < w_op_b};
            ALU_XOR:  o_ALUOutput = w_op_a ^ w_op_b;
            ALU_SRL:  o_ALUOutput = w_op_a >> w_shamt;
            ALU_SRA:  o_ALUOutput = 32'($signed(w_op_a) >>> w_shamt);
            ALU_OR:   o_ALUOutput = w_op_a | w_op_b;
            ALU_AND:  o_ALUOutput = w_op_a & w_op_b;
            ALU_BR:   o_ALUOutput = {31'b0, w_taken};
            default:  o_ALUOutput = '0;
        endcase
    end

    assign w_is_jal    = (i_ALUop == OP_JAL);
    assign w_is_jalr   = (i_ALUop == OP_JALR);
    assign w_is_branch = (i_ALUop == OP_BRANCH);

    // Resolve the redirect target; non-jumps report the fall-through PC
    always_comb begin
        o_jmp_pc = i_NPC + 32'd4;
        if (w_is_jal || w_is_branch) begin
            o_jmp_pc = i_NPC + i_Imm_SignExt;
        end else if (w_is_jalr) begin
            o_jmp_pc = (i_A + i_Imm_SignExt) & ~32'h1;
        end
    end

    assign w_jmp_req = i_ex_state.valid & (w_is_jal | w_is_jalr | (w_is_branch & w_taken));

`ifdef ALU_JMP_MISALIGN_EN
    assign w_misaligned = w_jmp_req & o_jmp_pc[1];
`else
    assign w_misaligned = 1'b0;
`endif

    assign o_jmp = w_jmp_req & ~w_misaligned;

    // Capture the EX/MEM entry; reset discards whatever is in EX this cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_state <= '0;
        end else begin
            r_mem_state.pc         <= i_ex_state.pc;
            r_mem_state.alu_out    <= o_ALUOutput;
            r_mem_state.store_data <= i_B;
            r_mem_state.rd         <= i_ex_state.rd;
            r_mem_state.func3      <= i_ex_state.func3;
            r_mem_state.mem_read   <= i_ex_state.valid & (i_ALUop == OP_LOAD);
            r_mem_state.mem_write  <= i_ex_state.valid & (i_ALUop == OP_STORE);
            r_mem_state.reg_write  <= i_ex_state.valid & ~w_is_branch & (i_ALUop != OP_STORE)
                                      & (i_ex_state.rd != 5'd0) & ~w_misaligned;
            r_mem_state.valid      <= i_ex_state.valid;
            r_mem_state.misaligned <= w_misaligned;
        end
    end

    assign o_mem_state = r_mem_state;

endmodule

// File: tb/tb_rv32_ex_alu.sv
// tb/tb_rv32_ex_alu.sv - directed self-checking bench for rv32_ex_alu
import rv32_pipe_pkg::*;

module tb_rv32_ex_alu;

`ifdef ALU_JMP_MISALIGN_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] a, b, imm, npc;
    logic [6:0]  aluop;
    logic [2:0]  func3;
    logic        func7;
    EX_STATE     ex_state;
    logic [31:0] alu_out;
    MEM_STATE    mem_state;
    logic [31:0] jmp_pc;
    logic        jmp;

    int errors = 0;
    int checks = 0;

    rv32_ex_alu dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_A           (a),
        .i_B           (b),
        .i_Imm_SignExt (imm),
        .i_NPC         (npc),
        .i_ALUop       (aluop),
        .i_func3       (func3),
        .i_func7       (func7),
        .i_ex_state    (ex_state),
        .o_ALUOutput   (alu_out),
        .o_mem_state   (mem_state),
        .o_jmp_pc      (jmp_pc),
        .o_jmp         (jmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vimm,
                         input logic [31:0] vnpc, input logic [4:0] rd, input logic v);
        @(negedge clk);
        aluop          = op;
        func3          = f3;
        func7          = f7;
        a              = va;
        b              = vb;
        imm            = vimm;
        npc            = vnpc;
        ex_state.pc    = vnpc;
        ex_state.ALUOp = op;
        ex_state.func3 = f3;
        ex_state.func7 = f7;
        ex_state.rd    = rd;
        ex_state.valid = v;
        #1;
    endtask

    task automatic wait_reg();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a = '0; b = '0; imm = '0; npc = '0;
        aluop = '0; func3 = '0; func7 = 1'b0;
        ex_state = '0;
        drive(OP_LOAD, 3'b010, 1'b0, 32'h100, 32'h0, 32'h4, 32'h0, 5'd3, 1'b1);
        wait_reg();
        wait_reg();
        check("reset_mem_state_zero", {31'b0, |mem_state}, 32'd0);
        reset = 1'b0;

        drive(OP_OP, F3_ADD, 1'b0, 32'd7, 32'd5, 32'd0, 32'd0, 5'd1, 1'b1);
        check("add", alu_out, 32'd12);
        drive(OP_OP, F3_ADD, 1'b1, 32'd7, 32'd5, 32'd0, 32'd0, 5'd1, 1'b1);
        check("sub", alu_out, 32'd2);
        drive(OP_OP, F3_ADD, 1'b1, 32'd0, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1);
        check("sub_wrap", alu_out, 32'hFFFFFFFF);
        drive(OP_IMM, F3_SR, 1'b1, 32'h80000000, 32'd0, 32'd4, 32'd0, 5'd1, 1'b1);
        check("srai", alu_out, 32'hF8000000);
        drive(OP_IMM, F3_SR, 1'b0, 32'h80000000, 32'd0, 32'd4, 32'd0, 5'd1, 1'b1);
        check("srli", alu_out, 32'h08000000);
        drive(OP_OP, F3_SLT, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1);
        check("slt", alu_out, 32'd1);
        drive(OP_OP, F3_SLTU, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1);
        check("sltu", alu_out, 32'd0);
        drive(OP_IMM, F3_SLTU, 1'b0, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd1, 1'b1);
        check("sltiu_signext", alu_out, 32'd1);
        drive(OP_OP, F3_SLL, 1'b0, 32'h0000000F, 32'h00000024, 32'd0, 32'd0, 5'd1, 1'b1);
        check("sll_shamt5", alu_out, 32'h000000F0);
        drive(OP_LUI, 3'b000, 1'b0, 32'hDEAD0000, 32'd0, 32'h12345000, 32'h80, 5'd1, 1'b1);
        check("lui", alu_out, 32'h12345000);
        drive(OP_AUIPC, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h100, 5'd1, 1'b1);
        check("auipc", alu_out, 32'h1100);
        check("auipc_no_jmp", {31'b0, jmp}, 32'd0);

        drive(OP_BRANCH, F3_BEQ, 1'b0, 32'd3, 32'd3, 32'hFFFFFFF8, 32'd100, 5'd0, 1'b1);
        check("beq_jmp", {31'b0, jmp}, 32'd1);
        check("beq_pc", jmp_pc, 32'd92);
        check("beq_out", alu_out, 32'd1);
        drive(OP_BRANCH, F3_BNE, 1'b0, 32'd3, 32'd3, 32'hFFFFFFF8, 32'd100, 5'd0, 1'b1);
        check("bne_jmp", {31'b0, jmp}, 32'd0);
        check("bne_out", alu_out, 32'd0);
        drive(OP_BRANCH, F3_BLT, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h200, 5'd0, 1'b1);
        check("blt_jmp", {31'b0, jmp}, 32'd1);
        check("blt_pc", jmp_pc, 32'h210);
        drive(OP_BRANCH, F3_BLTU, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h200, 5'd0, 1'b1);
        check("bltu_jmp", {31'b0, jmp}, 32'd0);
        drive(OP_BRANCH, F3_BGEU, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h200, 5'd0, 1'b1);
        check("bgeu_jmp", {31'b0, jmp}, 32'd1);
        drive(OP_BRANCH, 3'b010, 1'b0, 32'd3, 32'd3, 32'h10, 32'h200, 5'd0, 1'b1);
        check("br_f3_010_never", {31'b0, jmp}, 32'd0);
        drive(OP_BRANCH, F3_BEQ, 1'b0, 32'd3, 32'd3, 32'hFFFFFFF8, 32'd100, 5'd0, 1'b0);
        check("beq_invalid_jmp", {31'b0, jmp}, 32'd0);

        drive(OP_JALR, 3'b000, 1'b0, 32'h1001, 32'd0, 32'd2, 32'h40, 5'd1, 1'b1);
        check("jalr_pc", jmp_pc, 32'h1002);
        check("jalr_out", alu_out, 32'h44);
        check("jalr_jmp", {31'b0, jmp}, {31'b0, ~MIS});

        drive(OP_JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'h6, 32'h40, 5'd1, 1'b1);
        check("jal_pc", jmp_pc, 32'h46);
        check("jal_jmp", {31'b0, jmp}, {31'b0, ~MIS});
        wait_reg();
        check("jal_mem_valid", {31'b0, mem_state.valid}, 32'd1);
        check("jal_mem_misaligned", {31'b0, mem_state.misaligned}, {31'b0, MIS});
        check("jal_mem_reg_write", {31'b0, mem_state.reg_write}, {31'b0, ~MIS});
        check("jal_mem_alu_out", mem_state.alu_out, 32'h44);

        drive(7'b1111111, 3'b000, 1'b0, 32'd5, 32'd6, 32'd7, 32'h40, 5'd1, 1'b1);
        check("unknown_out", alu_out, 32'd0);
        check("unknown_jmp", {31'b0, jmp}, 32'd0);

        drive(OP_LOAD, 3'b010, 1'b0, 32'h100, 32'hABCD, 32'd4, 32'h300, 5'd5, 1'b1);
        wait_reg();
        check("lw_mem_alu_out", mem_state.alu_out, 32'h104);
        check("lw_mem_read", {31'b0, mem_state.mem_read}, 32'd1);
        check("lw_mem_write", {31'b0, mem_state.mem_write}, 32'd0);
        check("lw_reg_write", {31'b0, mem_state.reg_write}, 32'd1);
        check("lw_rd", {27'b0, mem_state.rd}, 32'd5);
        check("lw_pc", mem_state.pc, 32'h300);
        check("lw_func3", {29'b0, mem_state.func3}, 32'd2);

        drive(OP_STORE, 3'b010, 1'b0, 32'h200, 32'h12345678, 32'h8, 32'h304, 5'd7, 1'b1);
        wait_reg();
        check("sw_mem_alu_out", mem_state.alu_out, 32'h208);
        check("sw_mem_write", {31'b0, mem_state.mem_write}, 32'd1);
        check("sw_reg_write", {31'b0, mem_state.reg_write}, 32'd0);
        check("sw_store_data", mem_state.store_data, 32'h12345678);

        drive(OP_OP, F3_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 32'h308, 5'd0, 1'b1);
        wait_reg();
        check("rd0_reg_write", {31'b0, mem_state.reg_write}, 32'd0);
        check("rd0_valid", {31'b0, mem_state.valid}, 32'd1);

        drive(OP_LOAD, 3'b010, 1'b0, 32'h100, 32'd0, 32'd4, 32'h30C, 5'd5, 1'b0);
        wait_reg();
        check("inv_valid", {31'b0, mem_state.valid}, 32'd0);
        check("inv_mem_read", {31'b0, mem_state.mem_read}, 32'd0);
        check("inv_reg_write", {31'b0, mem_state.reg_write}, 32'd0);

        drive(OP_LOAD, 3'b010, 1'b0, 32'h100, 32'd0, 32'd4, 32'h310, 5'd5, 1'b1);
        reset = 1'b1;
        #1;
        check("reset_comb_follows", alu_out, 32'h104);
        wait_reg();
        check("reset_midinstr_zero", {31'b0, |mem_state}, 32'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
